byte_elastic_fifo: RTL and testbench
====================================

Name: byte_elastic_fifo

Overview:
- Elastic byte buffer sitting directly upstream of the 8-bit double-inverter buffer stage.
- Accepts bytes from a producer over a valid/ready handshake and stores up to DEPTH entries.
- Presents the oldest byte, show-ahead, on out_data. out_data drives the inverter stage's 8-bit data input.
- Decouples producer stalls from the downstream consumer and reports occupancy for debug.

Parameters:
- WIDTH, 8, data width in bits; must match the downstream stage's 8-bit input.
- DEPTH, 4, number of storage entries; power of two, >= 2.
- CW, $clog2(DEPTH)+1, width of count output; derived, not overridden.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  producer has a byte on in_data.
- in_data  input  WIDTH  byte to store.
- in_ready  output  1  FIFO can accept a byte this cycle.
- out_valid  output  1  out_data holds a valid byte.
- out_data  output  WIDTH  oldest stored byte (show-ahead); feeds the downstream inverter stage.
- out_ready  input  1  consumer takes out_data this cycle.
- count  output  CW  current occupancy, 0..DEPTH.

Behaviour:
- Reset (reset_n low, asynchronous assert, synchronous-to-clk deassert handled externally):
  - wr_ptr=0, rd_ptr=0, count=0, out_valid=0.
  - in_ready=0 while reset_n is low.
  - Storage contents are not reset; out_data is don't-care while out_valid=0.
- Push occurs on an edge where in_valid&in_ready.
  - in_data is written to mem[wr_ptr] and wr_ptr increments modulo DEPTH.
- Pop occurs on an edge where out_valid&out_ready. rd_ptr increments modulo DEPTH.
- Occupancy:
  - count' = count + push - pop.
  - Simultaneous push and pop leaves count unchanged; both pointers advance.
- Output flags:
  - in_ready = reset_n & (count != DEPTH). Registered-equivalent: derived only from state, never from out_ready, so there is no combinational ready path.
  - out_valid = (count != 0).
  - out_data = mem[rd_ptr], combinational read of the array.
- Latency: a byte pushed at edge N is visible with out_valid=1 after edge N. Minimum 1-cycle fall-through; there is no same-cycle bypass when empty.
- Full (count=DEPTH): in_ready=0 and in_valid is ignored. A pop in the same cycle frees the slot; in_ready rises after that edge.
- Empty (count=0): out_valid=0 and out_ready is ignored. A push with out_ready=1 in the same cycle is not popped that cycle.
- Wrap-around: pointers are log2(DEPTH) bits and wrap naturally. Ordering is strictly FIFO across wraps.
- Producer rules: in_data must be stable while in_valid=1 and in_ready=0. The FIFO does not check this.
- Consumer contract: out_data and out_valid stay stable while out_valid=1 and out_ready=0.
- Reset mid-operation: all stored bytes are discarded immediately (count=0, out_valid=0). The FIFO resumes empty after deassertion.
- No overflow or underflow state is possible; illegal handshakes are simply not accepted.

Test Plan:
- Reset then idle: reset_n low for 3 cycles -> count=0, out_valid=0, in_ready=0. After release -> in_ready=1.
- Ordered fill and drain: push 0x11,0x22,0x33,0x44 with out_ready=0 -> count=4, in_ready=0, out_data=0x11. Then out_ready=1 for 4 cycles -> out_data sequence 0x11,0x22,0x33,0x44, then count=0.
- Push while full: with count=4, in_valid=1, in_data=0x55 and out_ready=0 -> byte not stored. Next pop yields 0x11, and 0x55 is accepted on the following cycle.
- Simultaneous push/pop at count=2: holding in_valid=1 and out_ready=1 for 6 cycles with bytes 0xA0..0xA5 -> count stays 2 and pointers wrap. Output order is the two old bytes, then 0xA0.. in order.
- Empty fall-through: count=0, push 0xC3 with out_ready=1 -> out_valid=0 that cycle. out_valid=1 with out_data=0xC3 the next cycle, then popped. Downstream buffer output equals 0xC3.
- Reset mid-stream: count=3, assert reset_n low asynchronously between edges -> out_valid=0 and count=0 immediately. After release, push 0x7E -> out_data=0x7E (no stale data).

Source files
------------

// File: rtl/byte_elastic_fifo.sv
// rtl/byte_elastic_fifo.sv - show-ahead elastic byte FIFO feeding the 8-bit inverter buffer stage
module byte_elastic_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [CW-1:0]    count
);

    localparam int            PW         = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;
    logic             push;
    logic             pop;

    // Flags come only from stored occupancy, so out_ready never reaches in_ready.
    assign in_ready  = reset_n & (count_q != FULL_COUNT);
    assign out_valid = (count_q != '0);
    assign out_data  = mem_q[rd_ptr_q];
    assign count     = count_q;

    assign push = in_valid  & in_ready;
    assign pop  = out_valid & out_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately left unreset; out_data is only meaningful with out_valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

endmodule

// File: tb/tb_byte_elastic_fifo.sv
// tb/tb_byte_elastic_fifo.sv - scoreboard testbench for byte_elastic_fifo
module tb_byte_elastic_fifo;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic             clk;
    logic             reset_n;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic [CW-1:0]    count;

    int checks = 0;
    int errors = 0;
    logic [WIDTH-1:0] sb [$];

    byte_elastic_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One handshake cycle, called just after a falling edge.
    task automatic cycle(input logic iv, input logic [WIDTH-1:0] id, input logic ordy);
        logic m_push;
        logic m_pop;
        logic [WIDTH-1:0] exp_data;
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        #1;
        check("in_ready_pre", 32'(in_ready), 32'(sb.size() != DEPTH));
        check("out_valid_pre", 32'(out_valid), 32'(sb.size() != 0));
        m_push = iv && (sb.size() != DEPTH);
        m_pop  = ordy && (sb.size() != 0);
        if (m_pop) begin
            exp_data = sb.pop_front();
            check("pop_data", 32'(out_data), 32'(exp_data));
        end
        if (m_push) begin
            sb.push_back(id);
        end
        @(posedge clk);
        #1;
        check("count", 32'(count), 32'(sb.size()));
        @(negedge clk);
    endtask

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_count", 32'(count), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        reset_n = 1'b1;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        cycle(1'b1, 8'h11, 1'b0);
        cycle(1'b1, 8'h22, 1'b0);
        cycle(1'b1, 8'h33, 1'b0);
        cycle(1'b1, 8'h44, 1'b0);
        check("full_count", 32'(count), 32'd4);
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("full_head", 32'(out_data), 32'h11);

        cycle(1'b1, 8'h55, 1'b0);
        check("full_head_hold", 32'(out_data), 32'h11);
        cycle(1'b1, 8'h55, 1'b1);
        check("after_pop_in_ready", 32'(in_ready), 32'd1);
        cycle(1'b1, 8'h55, 1'b0);
        repeat (4) cycle(1'b0, 8'h00, 1'b1);
        check("drained_count", 32'(count), 32'd0);

        cycle(1'b1, 8'h01, 1'b0);
        cycle(1'b1, 8'h02, 1'b0);
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, 8'hA0 + 8'(i), 1'b1);
            check("simul_count", 32'(count), 32'd2);
        end
        repeat (2) cycle(1'b0, 8'h00, 1'b1);

        cycle(1'b1, 8'hC3, 1'b1);
        check("fallthru_valid", 32'(out_valid), 32'd1);
        check("fallthru_data", 32'(out_data), 32'hC3);
        cycle(1'b0, 8'h00, 1'b1);

        cycle(1'b1, 8'h31, 1'b0);
        cycle(1'b1, 8'h32, 1'b0);
        cycle(1'b1, 8'h33, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst_count", 32'(count), 32'd0);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        sb.delete();
        @(negedge clk);
        reset_n = 1'b1;
        cycle(1'b1, 8'h7E, 1'b0);
        check("post_rst_data", 32'(out_data), 32'h7E);
        cycle(1'b0, 8'h00, 1'b1);

        repeat (80) cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
        repeat (DEPTH + 1) cycle(1'b0, 8'h00, 1'b1);
        check("final_count", 32'(count), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
